decode_pipe_stage: RTL

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage_pkg.sv | 69 ++++++
 rtl/decode_pipe_stage_if.sv | 44 ++++
 rtl/decode_pipe_stage_regfile_bypass.sv | 52 +++++
 rtl/decode_pipe_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// Shared LEGv8 decode definitions: opcode constants, alu_op encodings and instruction field bit positions.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package decode_pipe_stage_pkg;

  // Full 11-bit opcodes (instr[31:21])
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  // Short opcodes: CBZ is an 8-bit prefix, B a 6-bit prefix
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_CB  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 21;
  localparam int CBZ_OPC_LSB = 24;
  localparam int B_OPC_LSB   = 26;
  localparam int RM_MSB      = 20;
  localparam int RM_LSB      = 16;
  localparam int RN_MSB      = 9;
  localparam int RN_LSB      = 5;
  localparam int RT_MSB      = 4;
  localparam int RT_LSB      = 0;
  localparam int D_IMM_MSB   = 20;
  localparam int D_IMM_LSB   = 12;
  localparam int CB_IMM_MSB  = 23;
  localparam int CB_IMM_LSB  = 5;
  localparam int B_IMM_MSB   = 25;
  localparam int B_IMM_LSB   = 0;

  typedef enum logic [2:0] {FMT_R, FMT_LD, FMT_ST, FMT_CB, FMT_B, FMT_ILL} fmt_e;

  typedef struct packed {
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic fmt_e decode_fmt(input logic [31:0] instr);
    fmt_e f;
    if (instr[OPC_MSB:B_OPC_LSB] == OP_B) begin
      f = FMT_B;
    end else if (instr[OPC_MSB:CBZ_OPC_LSB] == OP_CBZ) begin
      f = FMT_CB;
    end else begin
      case (instr[OPC_MSB:OPC_LSB])
        OP_LDUR:                        f = FMT_LD;
        OP_STUR:                        f = FMT_ST;
        OP_ADD, OP_SUB, OP_AND, OP_ORR: f = FMT_R;
        default:                        f = FMT_ILL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Handshake and data bundle of the decode stage: upstream instr, write-back port, downstream decoded slot.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports: master = instruction source / write-back / consumer side; slave = the decode stage.
interface decode_pipe_stage_if #(
  parameter int WORD = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [WORD-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] read_data1;
  logic [WORD-1:0] read_data2;
  logic [WORD-1:0] ext_addr;
  logic [10:0]     alu_con_instr;
  logic            uncondbranch;
  logic            branch;
  logic            mem_read;
  logic            mem_to_reg;
  logic            mem_write;
  logic            alu_src;
  logic            reg_write;
  logic            illegal;
  logic [1:0]      alu_op;
  logic [4:0]      rd;

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, read_data1, read_data2, ext_addr, alu_con_instr,
           uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, illegal, alu_op, rd
  );

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, read_data1, read_data2, ext_addr, alu_con_instr,
           uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, illegal, alu_op, rd
  );
endinterface

// File: rtl/decode_pipe_stage_regfile_bypass.sv
// Register file with NUM_REGS entries, last index hard-wired to zero (XZR), optional write-back bypass.
// Latency: combinational read, write on clk edge.
// Backpressure: none.
// Ports: clk/rst, i_wb_* write port, i_rd_addr1/2 -> o_rd_data1/2 read ports.
// Macro DECODE_BYPASS_EN: reads hitting the same-cycle write return i_wb_data instead of the stored value.
module regfile_bypass #(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [WORD-1:0] i_wb_data,
  input  logic [4:0]      i_rd_addr1,
  input  logic [4:0]      i_rd_addr2,
  output logic [WORD-1:0] o_rd_data1,
  output logic [WORD-1:0] o_rd_data2
);
  localparam int            AW  = $clog2(NUM_REGS);
  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

  logic [WORD-1:0] r_regs [NUM_REGS];
  logic [AW-1:0]   w_wa, w_ra1, w_ra2;
  logic [WORD-1:0] w_q1, w_q2;

  // Upper address bits beyond the register count are simply dropped
  assign w_wa  = i_wb_addr[AW-1:0];
  assign w_ra1 = i_rd_addr1[AW-1:0];
  assign w_ra2 = i_rd_addr2[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wb_en && (w_wa != XZR)) begin
      r_regs[w_wa] <= i_wb_data;
    end
  end

  assign w_q1 = (w_ra1 == XZR) ? '0 : r_regs[w_ra1];
  assign w_q2 = (w_ra2 == XZR) ? '0 : r_regs[w_ra2];

`ifdef DECODE_BYPASS_EN
  assign o_rd_data1 = (i_wb_en && (w_wa == w_ra1) && (w_ra1 != XZR)) ? i_wb_data : w_q1;
  assign o_rd_data2 = (i_wb_en && (w_wa == w_ra2) && (w_ra2 != XZR)) ? i_wb_data : w_q2;
`else
  // Same-cycle write is not visible; downstream forwarding covers this case
  assign o_rd_data1 = w_q1;
  assign o_rd_data2 = w_q2;
`endif

endmodule

// File: rtl/decode_pipe_stage.sv
// LEGv8 decode stage: field decode, register read, sign-extended immediate and control, load-use stall.
// Latency: 1 cycle from accepted instruction to output register.
// Backpressure: holds output while out_valid && !out_ready; stalls upstream on load-use hazard (one bubble).
// Ports: clk, rst (sync, active-high), bus (decode_pipe_stage_if.slave) carrying all handshake/data signals.
// Macro DECODE_BYPASS_EN: enables write-back bypass inside regfile_bypass.
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_pipe_stage_if.slave   bus
);
  localparam int            AW  = $clog2(NUM_REGS);
  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

  fmt_e            w_fmt;
  ctrl_t           w_ctrl;
  logic [WORD-1:0] w_ext;
  logic [4:0]      w_rn, w_rm, w_rt, w_rs2, w_rd;
  logic            w_use1, w_use2;
  logic [WORD-1:0] w_rdata1, w_rdata2;
  logic            w_hazard, w_in_ready, w_accept;

  logic            r_out_valid;
  ctrl_t           r_ctrl;
  logic [4:0]      r_rd;
  logic [10:0]     r_alu_con;
  logic [WORD-1:0] r_ext, r_rd1, r_rd2;

  assign w_fmt = decode_fmt(bus.instr);
  assign w_rn  = bus.instr[RN_MSB:RN_LSB];
  assign w_rm  = bus.instr[RM_MSB:RM_LSB];
  assign w_rt  = bus.instr[RT_MSB:RT_LSB];
  assign w_rd  = (w_fmt == FMT_ILL) ? 5'd0 : w_rt;

  // w_use1/w_use2 mark the read ports the instruction really consumes (for the hazard check)
  always_comb begin
    w_ctrl = '0;
    w_ext  = '0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_rs2  = w_rm;
    case (w_fmt)
      FMT_R: begin
        w_ctrl.alu_op    = ALU_OP_R;
        w_ctrl.reg_write = 1'b1;
        w_use1           = 1'b1;
        w_use2           = 1'b1;
      end
      FMT_LD: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_op     = ALU_OP_MEM;
        w_ext  = {{(WORD-9){bus.instr[D_IMM_MSB]}}, bus.instr[D_IMM_MSB:D_IMM_LSB]};
        w_use1 = 1'b1;
      end
      FMT_ST: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_MEM;
        w_ext  = {{(WORD-9){bus.instr[D_IMM_MSB]}}, bus.instr[D_IMM_MSB:D_IMM_LSB]};
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_rs2  = w_rt;
      end
      FMT_CB: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALU_OP_CB;
        w_ext  = {{(WORD-19){bus.instr[CB_IMM_MSB]}}, bus.instr[CB_IMM_MSB:CB_IMM_LSB]};
        w_use2 = 1'b1;
        w_rs2  = w_rt;
      end
      FMT_B: begin
        w_ctrl.uncondbranch = 1'b1;
        w_ext = {{(WORD-26){bus.instr[B_IMM_MSB]}}, bus.instr[B_IMM_MSB:B_IMM_LSB]};
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  regfile_bypass #(.WORD(WORD), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wb_en    (bus.wb_en),
    .i_wb_addr  (bus.wb_addr),
    .i_wb_data  (bus.wb_data),
    .i_rd_addr1 (w_rn),
    .i_rd_addr2 (w_rs2),
    .o_rd_data1 (w_rdata1),
    .o_rd_data2 (w_rdata2)
  );

  // Load-use: the load in the output register has not produced its data yet
  assign w_hazard = r_out_valid && r_ctrl.mem_read && (r_rd[AW-1:0] != XZR) &&
                    ((w_use1 && (w_rn[AW-1:0]  == r_rd[AW-1:0])) ||
                     (w_use2 && (w_rs2[AW-1:0] == r_rd[AW-1:0])));

  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_alu_con   <= '0;
      r_ext       <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ctrl      <= w_ctrl;
      r_rd        <= w_rd;
      r_alu_con   <= bus.instr[OPC_MSB:OPC_LSB];
      r_ext       <= w_ext;
      r_rd1       <= w_rdata1;
      r_rd2       <= w_rdata2;
    end else if (bus.out_ready) begin
      // Drained with nothing accepted (idle or hazard stall): slot goes empty
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.read_data1    = r_rd1;
  assign bus.read_data2    = r_rd2;
  assign bus.ext_addr      = r_ext;
  assign bus.alu_con_instr = r_alu_con;
  assign bus.uncondbranch  = r_ctrl.uncondbranch;
  assign bus.branch        = r_ctrl.branch;
  assign bus.mem_read      = r_ctrl.mem_read;
  assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
  assign bus.mem_write     = r_ctrl.mem_write;
  assign bus.alu_src       = r_ctrl.alu_src;
  assign bus.reg_write     = r_ctrl.reg_write;
  assign bus.illegal       = r_ctrl.illegal;
  assign bus.alu_op        = r_ctrl.alu_op;
  assign bus.rd            = r_rd;

endmodule
